// File: rtl/cpu5_exmem.sv
// cpu5 execute-to-memory boundary: two-entry skid buffer with registered ex_ready,
// plus branch resolution producing a one-cycle redirect pulse.
module cpu5_exmem #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_alu_y,
    input  logic            ex_alu_zero,
    input  logic [4:0]      ex_rd,
    input  logic            ex_regwrite,
    input  logic            ex_memread,
    input  logic            ex_memwrite,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic            ex_branch,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_alu_y,
    output logic [XLEN-1:0] mem_store_data,
    output logic [4:0]      mem_rd,
    output logic            mem_regwrite,
    output logic            mem_memread,
    output logic            mem_memwrite,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    typedef struct packed {
        logic [XLEN-1:0] alu_y;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
    } bundle_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

    occ_t    state, state_nxt;
    bundle_t main_q, skid_q, in_b;
    logic    accept, deliver, redirect_set;
    logic    load_main_in, load_main_skid, load_skid;

    // Occupancy transitions and entry load strobes; flush overrides everything.
    always_comb begin
        in_b.alu_y      = ex_alu_y;
        in_b.store_data = ex_store_data;
        in_b.rd         = ex_rd;
        in_b.regwrite   = ex_regwrite;
        in_b.memread    = ex_memread;
        in_b.memwrite   = ex_memwrite;

        accept         = ex_valid & ex_ready;
        deliver        = mem_valid & mem_ready;
        redirect_set   = accept & ex_branch & ex_alu_zero & ~flush;
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;

        case (state)
            EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    state_nxt    = ONE;
                end
            end
            ONE: begin
                if (deliver) begin
                    if (accept) load_main_in = 1'b1;
                    else        state_nxt    = EMPTY;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = TWO;
                end
            end
            TWO: begin
                if (deliver) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase

        if (flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= EMPTY;
            ex_ready       <= 1'b1;
            mem_valid      <= 1'b0;
            main_q         <= '0;
            skid_q         <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state     <= state_nxt;
            ex_ready  <= (state_nxt != TWO);
            mem_valid <= (state_nxt != EMPTY);
            if (load_main_in)        main_q <= in_b;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_b;
            redirect_valid <= redirect_set;
            if (redirect_set) redirect_pc <= ex_pc + ex_imm;
        end
    end

    assign mem_alu_y      = main_q.alu_y;
    assign mem_store_data = main_q.store_data;
    assign mem_rd         = main_q.rd;
    assign mem_regwrite   = main_q.regwrite;
    assign mem_memread    = main_q.memread;
    assign mem_memwrite   = main_q.memwrite;

endmodule

// File: tb/tb_cpu5_exmem.sv
// Bench for cpu5_exmem: directed vector table plus randomized traffic checked
// against a queue-based FIFO reference model.
module tb_cpu5_exmem;

    logic        clk = 1'b0;
    logic        resetn, flush, ex_valid, ex_ready;
    logic [31:0] ex_alu_y, ex_store_data, ex_pc, ex_imm;
    logic        ex_alu_zero, ex_regwrite, ex_memread, ex_memwrite, ex_branch;
    logic [4:0]  ex_rd;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_alu_y, mem_store_data;
    logic [4:0]  mem_rd;
    logic        mem_regwrite, mem_memread, mem_memwrite;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cpu5_exmem #(.XLEN(32)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_y(ex_alu_y), .ex_alu_zero(ex_alu_zero), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_store_data(ex_store_data), .ex_branch(ex_branch),
        .ex_pc(ex_pc), .ex_imm(ex_imm),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_alu_y(mem_alu_y), .mem_store_data(mem_store_data), .mem_rd(mem_rd),
        .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a capacity-2 FIFO; ready means fewer than two held.
    typedef struct packed {
        logic [31:0] y;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw, mrd, mwr;
    } bun_t;

    bun_t        m_q[$];
    bun_t        m_shown = '0;
    logic        m_ready = 1'b1;
    logic        m_rv = 1'b0;
    logic [31:0] m_rpc = '0;
    logic        m_en = 1'b0;

    always @(posedge clk) begin
        logic acc, dlv;
        bun_t b;
        if (!resetn) begin
            m_q.delete();
            m_shown = '0;
            m_ready = 1'b1;
            m_rv    = 1'b0;
            m_rpc   = '0;
            m_en    = 1'b1;
        end else if (m_en) begin
            acc = ex_valid & m_ready;
            dlv = (m_q.size() > 0) & mem_ready;
            m_rv = acc & ex_branch & ex_alu_zero & ~flush;
            if (m_rv) m_rpc = ex_pc + ex_imm;
            b = '{ex_alu_y, ex_store_data, ex_rd, ex_regwrite, ex_memread, ex_memwrite};
            if (flush) m_q.delete();
            else begin
                if (dlv) void'(m_q.pop_front());
                if (acc) m_q.push_back(b);
            end
            m_ready = (m_q.size() < 2);
            if (m_q.size() > 0) m_shown = m_q[0];
        end
        #1;
        if (m_en) begin
            chk("model mem_valid", 32'(mem_valid), 32'(m_q.size() > 0));
            chk("model ex_ready", 32'(ex_ready), 32'(m_ready));
            chk("model redirect_valid", 32'(redirect_valid), 32'(m_rv));
            chk("model redirect_pc", redirect_pc, m_rpc);
            chk("model mem_alu_y", mem_alu_y, m_shown.y);
            chk("model mem_store_data", mem_store_data, m_shown.sd);
            chk("model mem_ctl", {24'(mem_rd), 5'd0, mem_regwrite, mem_memread, mem_memwrite},
                {24'(m_shown.rd), 5'd0, m_shown.rw, m_shown.mrd, m_shown.mwr});
        end
    end

    typedef struct {
        logic        rst_n, fl, v;
        logic [31:0] y;
        logic        br, z;
        logic [31:0] pc, imm;
        logic        mr;
        logic        e_mv;
        logic [31:0] e_y;
        logic        e_rdy, e_rv;
        logic [31:0] e_rpc;
    } vec_t;

    localparam int unsigned NV = 30;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic rst_n, fl, v, input logic [31:0] y,
                                input logic br, z, input logic [31:0] pc, imm,
                                input logic mr, e_mv, input logic [31:0] e_y,
                                input logic e_rdy, e_rv, input logic [31:0] e_rpc);
        vec_t r;
        r.rst_n = rst_n; r.fl = fl; r.v = v; r.y = y; r.br = br; r.z = z;
        r.pc = pc; r.imm = imm; r.mr = mr; r.e_mv = e_mv; r.e_y = e_y;
        r.e_rdy = e_rdy; r.e_rv = e_rv; r.e_rpc = e_rpc;
        return r;
    endfunction

    initial begin
        resetn = 0; flush = 0; ex_valid = 0; ex_alu_y = 0; ex_store_data = 0;
        ex_pc = 0; ex_imm = 0; ex_alu_zero = 0; ex_regwrite = 0; ex_memread = 0;
        ex_memwrite = 0; ex_branch = 0; ex_rd = 0; mem_ready = 1;

        //             rst fl v  y            br z  pc           imm          mr  mv y            rdy rv rpc
        tbl[0]  = mk(0, 0, 1, 32'h99,       0, 0, 0,           0,           1,  0, 32'h0,       1, 0, 32'h0);
        tbl[1]  = mk(1, 0, 1, 32'h10,       0, 0, 0,           0,           1,  1, 32'h10,      1, 0, 32'h0);
        tbl[2]  = mk(1, 0, 1, 32'h20,       0, 0, 0,           0,           1,  1, 32'h20,      1, 0, 32'h0);
        tbl[3]  = mk(1, 0, 1, 32'h30,       0, 0, 0,           0,           1,  1, 32'h30,      1, 0, 32'h0);
        tbl[4]  = mk(1, 0, 1, 32'h40,       0, 0, 0,           0,           1,  1, 32'h40,      1, 0, 32'h0);
        tbl[5]  = mk(1, 0, 0, 32'h0,        0, 0, 0,           0,           1,  0, 32'h40,      1, 0, 32'h0);
        tbl[6]  = mk(1, 0, 1, 32'hA,        0, 0, 0,           0,           0,  1, 32'hA,       1, 0, 32'h0);
        tbl[7]  = mk(1, 0, 1, 32'hB,        0, 0, 0,           0,           0,  1, 32'hA,       0, 0, 32'h0);
        tbl[8]  = mk(1, 0, 1, 32'hC,        0, 0, 0,           0,           0,  1, 32'hA,       0, 0, 32'h0);
        tbl[9]  = mk(1, 0, 1, 32'hC,        0, 0, 0,           0,           0,  1, 32'hA,       0, 0, 32'h0);
        tbl[10] = mk(1, 0, 1, 32'hC,        0, 0, 0,           0,           0,  1, 32'hA,       0, 0, 32'h0);
        tbl[11] = mk(1, 0, 1, 32'hC,        0, 0, 0,           0,           1,  1, 32'hB,       1, 0, 32'h0);
        tbl[12] = mk(1, 0, 1, 32'hC,        0, 0, 0,           0,           1,  1, 32'hC,       1, 0, 32'h0);
        tbl[13] = mk(1, 0, 0, 32'h0,        0, 0, 0,           0,           1,  0, 32'hC,       1, 0, 32'h0);
        tbl[14] = mk(1, 0, 1, 32'h55,       1, 1, 32'h100,     32'hFFFFFFF0, 1, 1, 32'h55,      1, 1, 32'hF0);
        tbl[15] = mk(1, 0, 0, 32'h0,        0, 0, 0,           0,           1,  0, 32'h55,      1, 0, 32'hF0);
        tbl[16] = mk(1, 0, 1, 32'h66,       1, 0, 32'h100,     32'hFFFFFFF0, 1, 1, 32'h66,      1, 0, 32'hF0);
        tbl[17] = mk(1, 0, 1, 32'h77,       1, 1, 32'hFFFFFFFC, 32'h8,       1, 1, 32'h77,      1, 1, 32'h4);
        tbl[18] = mk(1, 0, 0, 32'h0,        0, 0, 0,           0,           0,  1, 32'h77,      1, 0, 32'h4);
        tbl[19] = mk(1, 0, 1, 32'h88,       0, 0, 0,           0,           0,  1, 32'h77,      0, 0, 32'h4);
        tbl[20] = mk(1, 1, 1, 32'h99,       1, 1, 32'h200,     32'h4,       0,  0, 32'h77,      1, 0, 32'h4);
        tbl[21] = mk(1, 0, 1, 32'h11,       0, 0, 0,           0,           1,  1, 32'h11,      1, 0, 32'h4);
        tbl[22] = mk(1, 1, 1, 32'h22,       1, 1, 32'h0,       32'h40,      1,  0, 32'h11,      1, 0, 32'h4);
        tbl[23] = mk(1, 0, 1, 32'h33,       1, 1, 32'h300,     32'h10,      0,  1, 32'h33,      1, 1, 32'h310);
        tbl[24] = mk(1, 1, 0, 32'h0,        0, 0, 0,           0,           0,  0, 32'h33,      1, 0, 32'h310);
        tbl[25] = mk(1, 0, 1, 32'h44,       0, 0, 0,           0,           0,  1, 32'h44,      1, 0, 32'h310);
        tbl[26] = mk(1, 0, 1, 32'h45,       0, 0, 0,           0,           0,  1, 32'h44,      0, 0, 32'h310);
        tbl[27] = mk(0, 0, 1, 32'h46,       0, 0, 0,           0,           0,  0, 32'h0,       1, 0, 32'h0);
        tbl[28] = mk(1, 0, 1, 32'h47,       0, 0, 0,           0,           0,  1, 32'h47,      1, 0, 32'h0);
        tbl[29] = mk(1, 0, 0, 32'h0,        0, 0, 0,           0,           1,  0, 32'h47,      1, 0, 32'h0);

        for (int i = 0; i < int'(NV); i++) begin
            @(negedge clk);
            resetn = tbl[i].rst_n; flush = tbl[i].fl; ex_valid = tbl[i].v;
            ex_alu_y = tbl[i].y; ex_store_data = tbl[i].y ^ 32'h5;
            ex_branch = tbl[i].br; ex_alu_zero = tbl[i].z;
            ex_pc = tbl[i].pc; ex_imm = tbl[i].imm; mem_ready = tbl[i].mr;
            ex_rd = 5'(i); ex_regwrite = ~tbl[i].br; ex_memread = 0; ex_memwrite = 0;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d mem_valid", i), 32'(mem_valid), 32'(tbl[i].e_mv));
            chk($sformatf("vec%0d mem_alu_y", i), mem_alu_y, tbl[i].e_y);
            chk($sformatf("vec%0d ex_ready", i), 32'(ex_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d redirect_valid", i), 32'(redirect_valid), 32'(tbl[i].e_rv));
            chk($sformatf("vec%0d redirect_pc", i), redirect_pc, tbl[i].e_rpc);
        end

        // Randomized traffic; the reference model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            resetn        = ($urandom_range(0, 99) != 0);
            flush         = ($urandom_range(0, 19) == 0);
            ex_valid      = ($urandom_range(0, 3) != 0);
            mem_ready     = ($urandom_range(0, 9) < 6);
            ex_alu_y      = $urandom;
            ex_store_data = $urandom;
            ex_rd         = 5'($urandom);
            ex_branch     = ($urandom_range(0, 3) == 0);
            ex_alu_zero   = $urandom_range(0, 1) == 1;
            ex_regwrite   = ~ex_branch & ($urandom_range(0, 1) == 1);
            ex_memread    = ~ex_branch & ($urandom_range(0, 1) == 1);
            ex_memwrite   = ~ex_branch & ~ex_memread & ($urandom_range(0, 1) == 1);
            ex_pc         = $urandom;
            ex_imm        = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC - 32'($urandom_range(0, 64)) : $urandom;
        end
        @(negedge clk);
        ex_valid = 0;
        @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
